// File: rtl/nor4_chk_pkg.sv
// nor4_chk_pkg: shared state encoding, default sizing and NOR reference for the self-checker
package nor4_chk_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int SETTLE_DEF = 1;
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  function automatic logic [31:0] nor_ref(input logic [31:0] a, input logic [31:0] b);
    return ~(a | b);
  endfunction
endpackage

// File: rtl/nor4_vec_counter.sv
// nor4_vec_counter: sweep index register split into operand halves, with last-vector flag
module nor4_vec_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic             last,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);
  logic [2*WIDTH-1:0] idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + (2*WIDTH)'(1);
  assign last = &idx;
  assign {a, b} = idx;
endmodule

// File: rtl/nor4_self_checker.sv
// nor4_self_checker: exhaustive NOR sweep with pass/err_count/first-fail capture
// NOR4_CHK_STOP_ON_FAIL_EN: when defined, the sweep ends on the first mismatching vector
module nor4_self_checker
  import nor4_chk_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic [WIDTH-1:0]   y_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [WIDTH-1:0]   fail_y
);
  localparam int CW = 2*WIDTH+1;
  state_t state;
  logic [3:0] settle_cnt;
  logic clr, inc, last, mism, stop;
  logic [WIDTH-1:0] exp_y;
  logic [CW-1:0] err_next;
  assign exp_y = WIDTH'(nor_ref(32'(a_o), 32'(b_o)));
  assign mism = (state == CHECK) && (y_i != exp_y);
  assign err_next = err_count + CW'(mism);
  assign clr = start && (state == IDLE || state == DONE);
`ifdef NOR4_CHK_STOP_ON_FAIL_EN
  assign stop = last || mism;
`else
  assign stop = last;
`endif
  assign inc = (state == CHECK) && !stop;
  nor4_vec_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .last(last), .a(a_o), .b(b_o)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      settle_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_a <= '0;
      fail_b <= '0;
      fail_y <= '0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= DRIVE;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            fail_a <= '0;
            fail_b <= '0;
            fail_y <= '0;
          end
        DRIVE: begin
          state <= WAIT;
          settle_cnt <= '0;
        end
        WAIT: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == 4'(SETTLE_CYCLES-1)) state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
          // err_count still zero here means this is the first mismatch of the sweep
          if (mism && err_count == '0) begin
            fail_a <= a_o;
            fail_b <= b_o;
            fail_y <= y_i;
          end
          if (stop) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
          end else state <= DRIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nor4_self_checker.sv
// tb_nor4_self_checker: randomized fault boards checked against an exhaustive sweep model
module tb_nor4_self_checker;
  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] a_o, b_o, y_i, fail_a, fail_b, fail_y;
  logic busy, done, pass;
  logic [8:0] err_count;
  int total = 0, bad = 0, mode = 0;
  logic [3:0] mask [256];

  always #5 clk = ~clk;

  nor4_self_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_y(fail_y)
  );

  // board under test: 0 good NOR, 1 y[0] stuck low, 2 OR gate, 3 random corruption table
  always_comb begin
    y_i = ~(a_o | b_o);
    if (mode == 1) y_i = ~(a_o | b_o) & 4'b1110;
    else if (mode == 2) y_i = a_o | b_o;
    else if (mode == 3) y_i = ~(a_o | b_o) ^ mask[{a_o, b_o}];
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int board(input int a, input int b, input int v);
    int n = 15 - (a | b);
    if (mode == 1) return n & 14;
    if (mode == 2) return a | b;
    if (mode == 3) return n ^ int'(mask[v]);
    return n;
  endfunction

  task automatic model(output int errs, output int first, output int fy);
    errs = 0; first = -1; fy = 0;
    for (int v = 0; v < 256; v++) begin
      int y = board(v / 16, v % 16, v);
      if (y != 15 - ((v / 16) | (v % 16))) begin
        if (first < 0) begin first = v; fy = y; end
        errs++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"}, a_o, 0); check({tag, "_b"}, b_o, 0);
    check({tag, "_busy"}, busy, 0); check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0); check({tag, "_err"}, err_count, 0);
    check({tag, "_fa"}, fail_a, 0); check({tag, "_fb"}, fail_b, 0);
    check({tag, "_fy"}, fail_y, 0);
  endtask

  task automatic run(input int ign_at, input int rst_at);
    int cyc, e_err, e_first, e_fy, e_cyc, e_last;
    model(e_err, e_first, e_fy);
    e_cyc = 768; e_last = 255;
`ifdef NOR4_CHK_STOP_ON_FAIL_EN
    if (e_first >= 0) begin e_err = 1; e_cyc = 3 * (e_first + 1); e_last = e_first; end
`endif
    @(negedge clk) start = 1;
    @(posedge clk);
    @(negedge clk) start = 0;
    check("busy_go", busy, 1); check("done_clr", done, 0);
    check("err_clr", err_count, 0); check("fy_clr", fail_y, 0);
    check("a_start", a_o, 0); check("b_start", b_o, 0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == ign_at);
      if (cyc == rst_at) begin
        rst_n = 0;
        #1 check_reset_vals("mid_rst");
        @(negedge clk) rst_n = 1;
        return;
      end
    end
    start = 0;
    check("done_cyc", cyc, e_cyc);
    check("busy_end", busy, 0);
    check("pass", pass, e_err == 0 ? 1 : 0);
    check("err_count", err_count, e_err);
    check("fail_a", fail_a, e_first < 0 ? 0 : e_first / 16);
    check("fail_b", fail_b, e_first < 0 ? 0 : e_first % 16);
    check("fail_y", fail_y, e_fy);
    check("a_last", a_o, e_last / 16);
    check("b_last", b_o, e_last % 16);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mask[i] = 4'h0;
    #1 check_reset_vals("por");
    #12 rst_n = 1;
    mode = 0; run(0, 0);
    run(50, 0);
    mode = 1; run(0, 0);
    mode = 2; run(0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++)
        mask[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      mode = 3;
      if (k == 0) run(0, 100);
      run(0, 0);
    end
    mode = 0; run(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
